// File: rtl/mod_mult.sv
// mod_mult: sequential interleaved (MSB-first shift-add) modular multiplier.
//   outC = (a * b) mod p, one multiplier bit per clock. The result appears
//   WIDTH rising edges after the capture edge.
//
// Ports:
//   clk      - system clock, all state on rising edge
//   rst_n    - asynchronous active-low reset
//   opselect - start request, sampled only while rdy=1
//   a, b     - operands, each must be < p
//   p        - modulus, must be >= 2
//   outC     - registered result, held until the next operation completes
//   rdy      - idle and able to accept opselect
//   done     - one-cycle pulse when outC/err update
//   err      - last operation had invalid operands
module mod_mult #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             opselect,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] outC,
  output logic             rdy,
  output logic             done,
  output logic             err
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {StIdle, StRun} state_e;

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt;
  logic [WIDTH-1:0] r_b, w_b_nxt;
  logic [WIDTH-1:0] r_p, w_p_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic [CW-1:0]    r_idx, w_idx_nxt;
  logic [WIDTH-1:0] r_outc, w_outc_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;

  // Operand check is done on the values present at the capture edge,
  // which are exactly the values latched on that edge.
  logic w_invalid;
  assign w_invalid = (p[WIDTH-1:1] == '0) || (a >= p) || (b >= p);

  // One shift-add step, all in WIDTH+1 bits. Since r_acc < p and r_a < p,
  // neither 2R nor t+a can exceed 2p-1, so one conditional subtract each.
  logic [WIDTH:0]   w_p_ext;
  logic [WIDTH:0]   w_dbl;
  logic [WIDTH:0]   w_t1;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_t2;

  assign w_p_ext = {1'b0, r_p};
  assign w_dbl   = {r_acc, 1'b0};
  assign w_t1    = (w_dbl >= w_p_ext) ? (w_dbl - w_p_ext) : w_dbl;
  assign w_sum   = r_b[r_idx] ? (w_t1 + {1'b0, r_a}) : w_t1;
  assign w_t2    = (w_sum >= w_p_ext) ? WIDTH'(w_sum - w_p_ext) : WIDTH'(w_sum);

  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_p_nxt     = r_p;
    w_acc_nxt   = r_acc;
    w_idx_nxt   = r_idx;
    w_outc_nxt  = r_outc;
    w_err_nxt   = r_err;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (opselect) begin
          w_a_nxt = a;
          w_b_nxt = b;
          w_p_nxt = p;
          if (w_invalid) begin
            w_outc_nxt = '0;
            w_err_nxt  = 1'b1;
            w_done_nxt = 1'b1;
          end else begin
            w_acc_nxt   = '0;
            w_idx_nxt   = CW'(WIDTH - 1);
            w_state_nxt = StRun;
          end
        end
      end
      StRun: begin
        w_acc_nxt = w_t2;
        w_idx_nxt = r_idx - CW'(1);
        if (r_idx == '0) begin
          // err is only updated together with outC, on the done pulse.
          w_outc_nxt  = w_t2;
          w_err_nxt   = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_p     <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_outc  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_p     <= w_p_nxt;
      r_acc   <= w_acc_nxt;
      r_idx   <= w_idx_nxt;
      r_outc  <= w_outc_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign outC = r_outc;
  assign rdy  = (r_state == StIdle);
  assign done = r_done;
  assign err  = r_err;

endmodule
